// File: rtl/mmp_mixer.sv
// Per-channel volume scaling and saturated mixing of SCC/PSG/OPLL samples in
// front of the DAC serializer. Define MMP_MIXER_DCB_EN to add a DC blocker on the mix.
module mmp_mixer #(
  parameter int GAIN_SHIFT = 6,
  parameter int ACC_W      = 18,
  parameter int DCB_SHIFT  = 8
) (
  input  logic        i_CLK,
  input  logic        i_RST_n,
  input  logic        i_SMPL_STB,
  input  logic [15:0] i_SCC,
  input  logic [15:0] i_PSG,
  input  logic [15:0] i_OPLL,
  input  logic [7:0]  i_VOL_SCC,
  input  logic [7:0]  i_VOL_PSG,
  input  logic [7:0]  i_VOL_OPLL,
  output logic [15:0] o_SCC,
  output logic [15:0] o_PSG,
  output logic [15:0] o_OPLL,
  output logic [15:0] o_ALL,
  output logic        o_VALID,
  output logic        o_BUSY,
  output logic        o_CLIP,
  output logic        o_OVERRUN
);

  // Strobe contract: i_SMPL_STB is accepted only in IDLE; o_VALID is a
  // one-cycle pulse with no back-pressure, and outputs hold until the next pulse.
  typedef enum logic [2:0] {
    S_IDLE, S_M_SCC, S_M_PSG, S_M_OPLL, S_SUM, S_DCB, S_OUT
  } state_t;

  // Common width wide enough for the scaled product and the mix accumulator.
  localparam int SW = (ACC_W > 25) ? ACC_W : 25;
  localparam logic signed [SW-1:0] MAX_V = SW'(32767);
  localparam logic signed [SW-1:0] MIN_V = SW'(-32768);

  function automatic logic signed [15:0] sat16(input logic signed [SW-1:0] v);
    if (v > MAX_V)      return 16'sh7fff;
    else if (v < MIN_V) return 16'sh8000;
    else                return v[15:0];
  endfunction

  function automatic logic clips(input logic signed [SW-1:0] v);
    return (v > MAX_V) || (v < MIN_V);
  endfunction

  state_t state;

  logic signed [15:0] smp_scc, smp_psg, smp_opll;
  logic [7:0]         vol_scc, vol_psg, vol_opll;
  logic signed [15:0] res_scc, res_psg, res_opll, res_sum;

  logic signed [15:0] mul_a;
  logic [7:0]         mul_v;
  logic signed [24:0] prod;
  logic signed [SW-1:0] scaled;
  logic signed [ACC_W-1:0] acc;
  logic signed [SW-1:0] acc_w;

  // The single multiplier is shared by the three channel states.
  always_comb begin
    mul_a = smp_scc;
    mul_v = vol_scc;
    case (state)
      S_M_PSG:  begin mul_a = smp_psg;  mul_v = vol_psg;  end
      S_M_OPLL: begin mul_a = smp_opll; mul_v = vol_opll; end
      default:  ;
    endcase
  end

  assign prod   = 25'(mul_a) * 25'($signed({1'b0, mul_v}));
  assign scaled = SW'(prod >>> GAIN_SHIFT);
  assign acc    = ACC_W'(res_scc) + ACC_W'(res_psg) + ACC_W'(res_opll);
  assign acc_w  = SW'(acc);

`ifdef MMP_MIXER_DCB_EN
  logic signed [15:0] dcb_x1, dcb_y1, dcb_y;
  logic signed [19:0] dcb_v;
  logic signed [SW-1:0] dcb_w;

  assign dcb_v = 20'(res_sum) - 20'(dcb_x1) + 20'(dcb_y1) - 20'(dcb_y1 >>> DCB_SHIFT);
  assign dcb_w = SW'(dcb_v);
`endif

  assign o_BUSY = (state != S_IDLE);

  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state     <= S_IDLE;
      smp_scc   <= '0;
      smp_psg   <= '0;
      smp_opll  <= '0;
      vol_scc   <= '0;
      vol_psg   <= '0;
      vol_opll  <= '0;
      res_scc   <= '0;
      res_psg   <= '0;
      res_opll  <= '0;
      res_sum   <= '0;
      o_SCC     <= '0;
      o_PSG     <= '0;
      o_OPLL    <= '0;
      o_ALL     <= '0;
      o_VALID   <= 1'b0;
      o_CLIP    <= 1'b0;
      o_OVERRUN <= 1'b0;
`ifdef MMP_MIXER_DCB_EN
      dcb_x1    <= '0;
      dcb_y1    <= '0;
      dcb_y     <= '0;
`endif
    end else begin
      o_VALID <= 1'b0;
      if (i_SMPL_STB && state != S_IDLE) o_OVERRUN <= 1'b1;
      case (state)
        S_IDLE: begin
          if (i_SMPL_STB) begin
            smp_scc  <= i_SCC;
            smp_psg  <= i_PSG;
            smp_opll <= i_OPLL;
            vol_scc  <= i_VOL_SCC;
            vol_psg  <= i_VOL_PSG;
            vol_opll <= i_VOL_OPLL;
            state    <= S_M_SCC;
          end
        end
        S_M_SCC: begin
          res_scc <= sat16(scaled);
          if (clips(scaled)) o_CLIP <= 1'b1;
          state <= S_M_PSG;
        end
        S_M_PSG: begin
          res_psg <= sat16(scaled);
          if (clips(scaled)) o_CLIP <= 1'b1;
          state <= S_M_OPLL;
        end
        S_M_OPLL: begin
          res_opll <= sat16(scaled);
          if (clips(scaled)) o_CLIP <= 1'b1;
          state <= S_SUM;
        end
        S_SUM: begin
          res_sum <= sat16(acc_w);
          if (clips(acc_w)) o_CLIP <= 1'b1;
`ifdef MMP_MIXER_DCB_EN
          state <= S_DCB;
`else
          state <= S_OUT;
`endif
        end
`ifdef MMP_MIXER_DCB_EN
        S_DCB: begin
          dcb_y <= sat16(dcb_w);
          if (clips(dcb_w)) o_CLIP <= 1'b1;
          state <= S_OUT;
        end
`endif
        S_OUT: begin
          o_SCC   <= res_scc;
          o_PSG   <= res_psg;
          o_OPLL  <= res_opll;
          o_VALID <= 1'b1;
`ifdef MMP_MIXER_DCB_EN
          o_ALL   <= dcb_y;
          dcb_x1  <= res_sum;
          dcb_y1  <= dcb_y;
`else
          o_ALL   <= res_sum;
`endif
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmp_mixer.sv
// Directed bench for mmp_mixer: latency, scaling, saturation, overrun and reset abort.
// Define MMP_MIXER_DCB_EN to check the DC-blocker build.
module tb_mmp_mixer;

`ifdef MMP_MIXER_DCB_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 6;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb;
  logic [15:0] scc, psg, opll;
  logic [7:0]  vs, vp, vo;
  logic [15:0] o_scc, o_psg, o_opll, o_all;
  logic        o_valid, o_busy, o_clip, o_overrun;

  int n_vec = 0;
  int n_bad = 0;
  int x1 = 0;
  int y1 = 0;

  mmp_mixer dut (
    .i_CLK      (clk),
    .i_RST_n    (rst_n),
    .i_SMPL_STB (stb),
    .i_SCC      (scc),
    .i_PSG      (psg),
    .i_OPLL     (opll),
    .i_VOL_SCC  (vs),
    .i_VOL_PSG  (vp),
    .i_VOL_OPLL (vo),
    .o_SCC      (o_scc),
    .o_PSG      (o_psg),
    .o_OPLL     (o_opll),
    .o_ALL      (o_all),
    .o_VALID    (o_valid),
    .o_BUSY     (o_busy),
    .o_CLIP     (o_clip),
    .o_OVERRUN  (o_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference for o_ALL from already-saturated channel values.
  task automatic mix_expect(input int a, input int b, input int c, output int all);
    int s;
    s = sat(a + b + c);
`ifdef MMP_MIXER_DCB_EN
    all = sat(s - x1 + y1 - (y1 >>> 8));
    x1 = s;
    y1 = all;
`else
    all = s;
`endif
  endtask

  task automatic set_in(input int a, input int b, input int c,
                        input int va, input int vb, input int vc);
    scc = a[15:0]; psg = b[15:0]; opll = c[15:0];
    vs = va[7:0];  vp = vb[7:0];  vo = vc[7:0];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    stb = 1'b0;
    x1 = 0;
    y1 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_sample(input string tag, input int a, input int b, input int c,
                            input int va, input int vb, input int vc,
                            input int es, input int ep, input int eo);
    int cnt;
    int eall;
    @(negedge clk);
    set_in(a, b, c, va, vb, vc);
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    check({tag, "_busy"}, int'(o_busy), 1);
    cnt = 1;
    while (o_valid !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_lat"}, cnt, LAT);
    mix_expect(es, ep, eo, eall);
    check({tag, "_scc"},  int'($signed(o_scc)),  es);
    check({tag, "_psg"},  int'($signed(o_psg)),  ep);
    check({tag, "_opll"}, int'($signed(o_opll)), eo);
    check({tag, "_all"},  int'($signed(o_all)),  eall);
    @(negedge clk);
    check({tag, "_pulse"}, int'(o_valid), 0);
    check({tag, "_idle"},  int'(o_busy), 0);
    check({tag, "_hold"},  int'($signed(o_all)), eall);
  endtask

  initial begin
    int nval;
    int cap_s, cap_p, cap_o, cap_a, eall;

    rst_n = 1'b0;
    stb = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_scc", int'(o_scc), 0);
    check("rst_all", int'(o_all), 0);
    check("rst_valid", int'(o_valid), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_clip", int'(o_clip), 0);
    check("rst_ovr", int'(o_overrun), 0);
    rst_n = 1'b1;

    run_sample("unity", 1000, 2000, -500, 64, 64, 64, 1000, 2000, -500);
    check("unity_clip", int'(o_clip), 0);

    run_sample("chsat", 20000, 0, 0, 128, 64, 64, 32767, 0, 0);
    check("chsat_clip", int'(o_clip), 1);
    run_sample("chsat2", 100, 0, 0, 128, 64, 64, 200, 0, 0);
    check("chsat2_clip", int'(o_clip), 1);

    run_sample("mixsat", -30000, -30000, -30000, 64, 64, 64, -30000, -30000, -30000);
    check("mixsat_clip", int'(o_clip), 1);

    run_sample("floor", -1, 0, 0, 32, 64, 64, -1, 0, 0);
    run_sample("zerovol", -32768, 0, 0, 0, 64, 64, 0, 0, 0);
    // 1000*255/64 = 3984.375 -> 3984; -1000*255/64 floors to -3985.
    run_sample("vol255", 1000, -1000, 0, 255, 255, 64, 3984, -3985, 0);

    do_reset();
    check("ovr_clear", int'(o_overrun), 0);
    @(negedge clk);
    set_in(100, 200, 300, 64, 64, 64);
    stb = 1'b1;
    nval = 0;
    cap_s = 0; cap_p = 0; cap_o = 0; cap_a = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (o_valid === 1'b1) begin
        nval++;
        cap_s = int'($signed(o_scc));
        cap_p = int'($signed(o_psg));
        cap_o = int'($signed(o_opll));
        cap_a = int'($signed(o_all));
      end
      if (c == 2) begin
        set_in(5, 6, -7, 64, 64, 64);
        stb = 1'b1;
      end else begin
        stb = 1'b0;
      end
    end
    mix_expect(100, 200, 300, eall);
    check("ovr_nvalid", nval, 1);
    check("ovr_scc", cap_s, 100);
    check("ovr_psg", cap_p, 200);
    check("ovr_opll", cap_o, 300);
    check("ovr_all", cap_a, eall);
    check("ovr_flag", int'(o_overrun), 1);
    run_sample("ovr_next", 7, 8, 9, 64, 64, 64, 7, 8, 9);

    // Asynchronous reset in the middle of a computation.
    @(negedge clk);
    set_in(1111, 2222, 3333, 64, 64, 64);
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_scc", int'(o_scc), 0);
    check("abort_all", int'(o_all), 0);
    check("abort_busy", int'(o_busy), 0);
    check("abort_ovr", int'(o_overrun), 0);
    x1 = 0;
    y1 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nval = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (o_valid === 1'b1) nval++;
    end
    check("abort_novalid", nval, 0);
    run_sample("post_rst", 1000, 2000, -500, 64, 64, 64, 1000, 2000, -500);

`ifdef MMP_MIXER_DCB_EN
    do_reset();
    run_sample("dcb0", 1000, 0, 0, 64, 64, 64, 1000, 0, 0);
    check("dcb0_first", int'($signed(o_all)), 1000);
    run_sample("dcb1", 1000, 0, 0, 64, 64, 64, 1000, 0, 0);
    check("dcb1_decay", int'($signed(o_all)), 997);
    run_sample("dcb2", 1000, 0, 0, 64, 64, 64, 1000, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
